// File: rtl/std_multi_fifo_controller.sv
// Pointer/flag controller for CHANNELS virtual FIFOs sharing one synchronous RAM.
// Each channel owns a fixed DEPTH-word region; one push and one pop per cycle.
module std_multi_fifo_controller #(
  parameter int unsigned CHANNELS     = 4,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned AF_THRESHOLD = DEPTH - 1,
  parameter int unsigned AE_THRESHOLD = 1,
  localparam int unsigned CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int unsigned PTR_W       = $clog2(DEPTH),
  localparam int unsigned CNT_W       = $clog2(DEPTH + 1),
  localparam int unsigned ADDR_W      = $clog2(CHANNELS * DEPTH)
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [CHANNELS-1:0]            i_clear,
  input  logic                           i_push,
  input  logic [CH_W-1:0]                i_push_channel,
  input  logic                           i_pop,
  input  logic [CH_W-1:0]                i_pop_channel,
  output logic                           o_write_enable,
  output logic [ADDR_W-1:0]              o_write_address,
  output logic                           o_read_enable,
  output logic [ADDR_W-1:0]              o_read_address,
  output logic                           o_read_valid,
  output logic [CH_W-1:0]                o_read_channel,
  output logic [CHANNELS-1:0]            o_empty,
  output logic [CHANNELS-1:0]            o_almost_empty,
  output logic [CHANNELS-1:0]            o_almost_full,
  output logic [CHANNELS-1:0]            o_full,
  output logic [CHANNELS-1:0][CNT_W-1:0] o_word_count,
  output logic [CHANNELS-1:0]            o_overflow,
  output logic [CHANNELS-1:0]            o_underflow
);

  logic [PTR_W-1:0]    wp_q  [CHANNELS];
  logic [PTR_W-1:0]    wp_d  [CHANNELS];
  logic [PTR_W-1:0]    rp_q  [CHANNELS];
  logic [PTR_W-1:0]    rp_d  [CHANNELS];
  logic [CNT_W-1:0]    cnt_q [CHANNELS];
  logic [CNT_W-1:0]    cnt_d [CHANNELS];
  logic [CHANNELS-1:0] ovf_q, ovf_d, udf_q, udf_d;
  logic [CHANNELS-1:0] push_ok, pop_ok, ovf_set, udf_set;
  logic                rvalid_q;
  logic [CH_W-1:0]     rch_q, rch_d;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (32'(p) == DEPTH - 1) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin : flag_decode
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      o_word_count[c]   = cnt_q[c];
      o_empty[c]        = (cnt_q[c] == '0);
      o_full[c]         = (32'(cnt_q[c]) == DEPTH);
      o_almost_full[c]  = (32'(cnt_q[c]) >= AF_THRESHOLD);
      o_almost_empty[c] = (32'(cnt_q[c]) <= AE_THRESHOLD);
    end
  end

  // Out-of-range channel numbers match no channel, so the request vanishes silently.
  always_comb begin : request_decode
    push_ok         = '0;
    pop_ok          = '0;
    ovf_set         = '0;
    udf_set         = '0;
    o_write_address = '0;
    o_read_address  = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      if (32'(i_push_channel) == c) begin
        o_write_address = ADDR_W'(c * DEPTH + 32'(wp_q[c]));
        if (i_push && !i_clear[c]) begin
          push_ok[c] = !o_full[c];
          ovf_set[c] = o_full[c];
        end
      end
      if (32'(i_pop_channel) == c) begin
        o_read_address = ADDR_W'(c * DEPTH + 32'(rp_q[c]));
        if (i_pop && !i_clear[c]) begin
          pop_ok[c]  = !o_empty[c];
          udf_set[c] = o_empty[c];
        end
      end
    end
    o_write_enable = |push_ok;
    o_read_enable  = |pop_ok;
  end

  always_comb begin : next_state
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      wp_d[c]  = wp_q[c];
      rp_d[c]  = rp_q[c];
      cnt_d[c] = cnt_q[c];
      ovf_d[c] = ovf_q[c] | ovf_set[c];
      udf_d[c] = udf_q[c] | udf_set[c];
      if (i_clear[c]) begin
        wp_d[c]  = '0;
        rp_d[c]  = '0;
        cnt_d[c] = '0;
        ovf_d[c] = 1'b0;
        udf_d[c] = 1'b0;
      end else begin
        if (push_ok[c]) wp_d[c] = ptr_inc(wp_q[c]);
        if (pop_ok[c])  rp_d[c] = ptr_inc(rp_q[c]);
        if (push_ok[c] && !pop_ok[c])      cnt_d[c] = cnt_q[c] + CNT_W'(1);
        else if (pop_ok[c] && !push_ok[c]) cnt_d[c] = cnt_q[c] - CNT_W'(1);
      end
    end
    rch_d = o_read_enable ? i_pop_channel : rch_q;
  end

  // A clear in the cycle after a pop leaves read_valid alone: the RAM read already happened.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wp_q     <= '{default: '0};
      rp_q     <= '{default: '0};
      cnt_q    <= '{default: '0};
      ovf_q    <= '0;
      udf_q    <= '0;
      rvalid_q <= 1'b0;
      rch_q    <= '0;
    end else begin
      wp_q     <= wp_d;
      rp_q     <= rp_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      rvalid_q <= o_read_enable;
      rch_q    <= rch_d;
    end
  end

  assign o_overflow     = ovf_q;
  assign o_underflow    = udf_q;
  assign o_read_valid   = rvalid_q;
  assign o_read_channel = rch_q;

endmodule

// File: tb/tb_std_multi_fifo_controller.sv
// Directed table-driven bench: instance A (4 ch x 8) and instance B (3 ch x 6).
// Each vector drives one cycle of requests and checks the resulting outputs.
module tb_std_multi_fifo_controller;

  typedef struct {
    bit       b;
    bit       push;
    bit [1:0] pch;
    bit       pop;
    bit [1:0] qch;
    bit [3:0] clr;
    bit       we;
    bit [4:0] wa;
    bit       re;
    bit [4:0] ra;
    bit       rv;
    bit [1:0] rc;
    bit [1:0] ch;
    bit [3:0] cnt;
    bit       full, empty, af, ae, ovf, udf;
  } vec_t;

  logic clk;
  int   n_vec;
  int   n_bad;

  logic            a_rst, a_push, a_pop;
  logic [3:0]      a_clr;
  logic [1:0]      a_pch, a_qch;
  logic            a_we, a_re, a_rv;
  logic [4:0]      a_wa, a_ra;
  logic [1:0]      a_rc;
  logic [3:0]      a_empty, a_ae, a_af, a_full, a_ovf, a_udf;
  logic [3:0][3:0] a_cnt;

  logic            b_rst, b_push, b_pop;
  logic [2:0]      b_clr;
  logic [1:0]      b_pch, b_qch;
  logic            b_we, b_re, b_rv;
  logic [4:0]      b_wa, b_ra;
  logic [1:0]      b_rc;
  logic [2:0]      b_empty, b_ae, b_af, b_full, b_ovf, b_udf;
  logic [2:0][2:0] b_cnt;

  std_multi_fifo_controller #(.CHANNELS(4), .DEPTH(8)) u_dut_a (
    .i_clk(clk), .i_rst(a_rst), .i_clear(a_clr),
    .i_push(a_push), .i_push_channel(a_pch), .i_pop(a_pop), .i_pop_channel(a_qch),
    .o_write_enable(a_we), .o_write_address(a_wa),
    .o_read_enable(a_re), .o_read_address(a_ra),
    .o_read_valid(a_rv), .o_read_channel(a_rc),
    .o_empty(a_empty), .o_almost_empty(a_ae), .o_almost_full(a_af), .o_full(a_full),
    .o_word_count(a_cnt), .o_overflow(a_ovf), .o_underflow(a_udf)
  );

  std_multi_fifo_controller #(.CHANNELS(3), .DEPTH(6)) u_dut_b (
    .i_clk(clk), .i_rst(b_rst), .i_clear(b_clr),
    .i_push(b_push), .i_push_channel(b_pch), .i_pop(b_pop), .i_pop_channel(b_qch),
    .o_write_enable(b_we), .o_write_address(b_wa),
    .o_read_enable(b_re), .o_read_address(b_ra),
    .o_read_valid(b_rv), .o_read_channel(b_rc),
    .o_empty(b_empty), .o_almost_empty(b_ae), .o_almost_full(b_af), .o_full(b_full),
    .o_word_count(b_cnt), .o_overflow(b_ovf), .o_underflow(b_udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(bit b, bit push, int pch, bit pop, int qch, int clr,
                              bit we, int wa, bit re, int ra, bit rv, int rc,
                              int ch, int cnt, bit ovf, bit udf);
    vec_t v;
    int   depth;
    depth   = b ? 6 : 8;
    v.b     = b;     v.push = push; v.pch = 2'(pch); v.pop = pop; v.qch = 2'(qch);
    v.clr   = 4'(clr);
    v.we    = we;    v.wa = 5'(wa); v.re = re; v.ra = 5'(ra);
    v.rv    = rv;    v.rc = 2'(rc); v.ch = 2'(ch); v.cnt = 4'(cnt);
    v.full  = (cnt == depth);
    v.empty = (cnt == 0);
    v.af    = (cnt >= depth - 1);
    v.ae    = (cnt <= 1);
    v.ovf   = ovf;   v.udf = udf;
    return v;
  endfunction

  function automatic bit cmp(int idx, string nm, logic [31:0] got, logic [31:0] exp);
    if (got !== exp) begin
      $display("FAIL vec %0d %s: got %0d, expected %0d", idx, nm, got, exp);
      return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic drive_idle();
    a_push = 0; a_pop = 0; a_pch = 0; a_qch = 0; a_clr = 0;
    b_push = 0; b_pop = 0; b_pch = 0; b_qch = 0; b_clr = 0;
  endtask

  task automatic apply(input vec_t v, input int idx);
    bit ok;
    ok = 1'b1;
    drive_idle();
    if (v.b) begin
      b_push = v.push; b_pch = v.pch; b_pop = v.pop; b_qch = v.qch; b_clr = v.clr[2:0];
    end else begin
      a_push = v.push; a_pch = v.pch; a_pop = v.pop; a_qch = v.qch; a_clr = v.clr;
    end
    #2;
    ok &= cmp(idx, "write_enable", 32'(v.b ? b_we : a_we), 32'(v.we));
    ok &= cmp(idx, "read_enable",  32'(v.b ? b_re : a_re), 32'(v.re));
    if (v.we) ok &= cmp(idx, "write_address", 32'(v.b ? b_wa : a_wa), 32'(v.wa));
    if (v.re) ok &= cmp(idx, "read_address",  32'(v.b ? b_ra : a_ra), 32'(v.ra));
    @(posedge clk);
    #1;
    ok &= cmp(idx, "read_valid", 32'(v.b ? b_rv : a_rv), 32'(v.rv));
    if (v.rv) ok &= cmp(idx, "read_channel", 32'(v.b ? b_rc : a_rc), 32'(v.rc));
    ok &= cmp(idx, "word_count", v.b ? 32'(b_cnt[v.ch]) : 32'(a_cnt[v.ch]), 32'(v.cnt));
    ok &= cmp(idx, "full",  32'(v.b ? b_full[v.ch]  : a_full[v.ch]),  32'(v.full));
    ok &= cmp(idx, "empty", 32'(v.b ? b_empty[v.ch] : a_empty[v.ch]), 32'(v.empty));
    ok &= cmp(idx, "almost_full",  32'(v.b ? b_af[v.ch] : a_af[v.ch]), 32'(v.af));
    ok &= cmp(idx, "almost_empty", 32'(v.b ? b_ae[v.ch] : a_ae[v.ch]), 32'(v.ae));
    ok &= cmp(idx, "overflow",  32'(v.b ? b_ovf[v.ch] : a_ovf[v.ch]), 32'(v.ovf));
    ok &= cmp(idx, "underflow", 32'(v.b ? b_udf[v.ch] : a_udf[v.ch]), 32'(v.udf));
    n_vec++;
    if (!ok) n_bad++;
  endtask

  initial begin
    vec_t tbl[$];
    bit   ok;
    n_vec = 0;
    n_bad = 0;

    // Instance A: 4 channels x 8 words, AF=7, AE=1.
    tbl.push_back(mk(0, 0,0, 0,0, 0, 0,0, 0,0, 0,0, 2,0, 0,0));
    for (int i = 0; i < 8; i++) tbl.push_back(mk(0, 1,2, 0,0, 0, 1,16+i, 0,0, 0,0, 2,i+1, 0,0));
    tbl.push_back(mk(0, 1,2, 0,0, 0, 0,0, 0,0, 0,0, 2,8, 1,0));
    tbl.push_back(mk(0, 0,0, 0,0, 0, 0,0, 0,0, 0,0, 0,0, 0,0));
    for (int i = 0; i < 8; i++) tbl.push_back(mk(0, 0,0, 1,2, 0, 0,0, 1,16+i, 1,2, 2,7-i, 1,0));
    tbl.push_back(mk(0, 0,0, 0,0, 0, 0,0, 0,0, 0,0, 2,0, 1,0));
    tbl.push_back(mk(0, 0,0, 1,2, 0, 0,0, 0,0, 0,0, 2,0, 1,1));
    tbl.push_back(mk(0, 0,0, 0,0, 4, 0,0, 0,0, 0,0, 2,0, 0,0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 1,0, 0,0, 0, 1,i, 0,0, 0,0, 0,i+1, 0,0));
    for (int k = 0; k < 20; k++)
      tbl.push_back(mk(0, 1,0, 1,0, 0, 1,(3+k)%8, 1,k%8, 1,0, 0,3, 0,0));
    for (int i = 0; i < 8; i++) tbl.push_back(mk(0, 1,1, 0,0, 0, 1,8+i, 0,0, 0,0, 1,i+1, 0,0));
    tbl.push_back(mk(0, 1,1, 1,1, 0, 0,0, 1,8, 1,1, 1,7, 1,0));
    tbl.push_back(mk(0, 1,3, 1,3, 0, 1,24, 0,0, 0,0, 3,1, 0,1));
    tbl.push_back(mk(0, 1,0, 1,1, 1, 0,0, 1,9, 1,1, 0,0, 0,0));
    tbl.push_back(mk(0, 0,0, 0,0, 0, 0,0, 0,0, 0,0, 1,6, 1,0));
    tbl.push_back(mk(0, 1,0, 0,0, 0, 1,0, 0,0, 0,0, 0,1, 0,0));

    // Instance B: 3 channels x 6 words, AF=5, AE=1; channel 3 is out of range.
    tbl.push_back(mk(1, 0,0, 0,0, 0, 0,0, 0,0, 0,0, 2,0, 0,0));
    tbl.push_back(mk(1, 1,3, 1,3, 0, 0,0, 0,0, 0,0, 0,0, 0,0));
    for (int i = 0; i < 6; i++) tbl.push_back(mk(1, 1,2, 0,0, 0, 1,12+i, 0,0, 0,0, 2,i+1, 0,0));
    for (int i = 0; i < 6; i++) tbl.push_back(mk(1, 0,0, 1,2, 0, 0,0, 1,12+i, 1,2, 2,5-i, 0,0));
    for (int i = 0; i < 6; i++) tbl.push_back(mk(1, 1,2, 0,0, 0, 1,12+i, 0,0, 0,0, 2,i+1, 0,0));
    tbl.push_back(mk(1, 1,2, 0,0, 0, 0,0, 0,0, 0,0, 2,6, 1,0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 0,0, 1,2, 0, 0,0, 1,12+i, 1,2, 2,5-i, 1,0));

    drive_idle();
    a_rst = 1'b1;
    b_rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    a_rst = 1'b0;
    b_rst = 1'b0;

    foreach (tbl[i]) apply(tbl[i], i);

    // Reset B in the middle of a drain, with a pop still requested.
    drive_idle();
    b_rst = 1'b1;
    b_pop = 1'b1;
    b_qch = 2'd2;
    @(posedge clk);
    #1;
    ok = 1'b1;
    ok &= cmp(1000, "rst read_valid",   32'(b_rv),    32'd0);
    ok &= cmp(1000, "rst read_channel", 32'(b_rc),    32'd0);
    ok &= cmp(1000, "rst empty",        32'(b_empty), 32'b111);
    ok &= cmp(1000, "rst almost_empty", 32'(b_ae),    32'b111);
    ok &= cmp(1000, "rst almost_full",  32'(b_af),    32'd0);
    ok &= cmp(1000, "rst full",         32'(b_full),  32'd0);
    ok &= cmp(1000, "rst overflow",     32'(b_ovf),   32'd0);
    ok &= cmp(1000, "rst underflow",    32'(b_udf),   32'd0);
    ok &= cmp(1000, "rst word_count",   32'(b_cnt),   32'd0);
    n_vec++;
    if (!ok) n_bad++;
    b_rst = 1'b0;

    // After reset the write pointer of channel 2 is back at the region base.
    apply(mk(1, 1,2, 0,0, 0, 1,12, 0,0, 0,0, 2,1, 0,0), 1001);
    apply(mk(1, 0,0, 1,0, 0, 0,0, 0,0, 0,0, 0,0, 0,1), 1002);

    drive_idle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
